// File: rtl/dzcpu_useq.sv
// dzcpu_useq - microcode sequencer for the dzcpu core.
//
// Latches macro opcodes from the memory read path into the instruction
// register, then looks up the flow entry point in the main or CB flow LUT.
// It steps a micro-PC through the microcode ROM and turns each micro-op's
// flow field into datapath strobes. A flow ends on an end-of-flow code, or
// it is aborted by a per-instruction watchdog.
//
// Ports:
//   iClock      core clock, all state updates on posedge
//   iReset      synchronous active-high reset
//   iMdata      memory read data (opcode / CB second byte)
//   iMemReady   memory cycle complete, low stalls the sequencer
//   iFlagZ      current Z flag, used by conditional end-of-flow codes
//   iUop        ROM word at oUaddr: [12:10] flow, [9:5] op, [4:0] operand
//   iFlowIdx    main LUT result for oIr
//   iCbFlowIdx  CB LUT result for oIr
//   oIr         instruction register, drives both LUTs
//   oUaddr      micro-ROM address
//   oUopValid   datapath executes iUop[9:0] this cycle
//   oPcInc      increment macro PC this cycle
//   oFlagWe     flag-update strobe
//   oEof        one-cycle pulse on instruction retire
//   oUcodeErr   sticky watchdog error
//   oInstCount  retired-instruction counter
module dzcpu_useq #(
  parameter logic [4:0] P_JCB_OP     = 5'd0,
  parameter int         P_WDOG_LIMIT = 32
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [7:0]  iMdata,
  input  logic        iMemReady,
  input  logic        iFlagZ,
  input  logic [12:0] iUop,
  input  logic [7:0]  iFlowIdx,
  input  logic [7:0]  iCbFlowIdx,
  output logic [7:0]  oIr,
  output logic [7:0]  oUaddr,
  output logic        oUopValid,
  output logic        oPcInc,
  output logic        oFlagWe,
  output logic        oEof,
  output logic        oUcodeErr,
  output logic [15:0] oInstCount
);

  localparam int WDW = $clog2(P_WDOG_LIMIT + 1);

  typedef enum logic [1:0] {ST_FETCH, ST_DECODE, ST_EXEC} state_e;

  state_e          state_q, state_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      upc_q, upc_d;
  logic            cb_q, cb_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic            err_q, err_d;
  logic [15:0]     icount_q, icount_d;

  logic [2:0]      flowCode;
  logic [4:0]      opField;
  logic            incBit;
  logic            fuBit;
  logic            eofHit;
  logic            condEof;
  logic            isJcb;
  logic            active;
  logic [WDW-1:0]  wdogNext;
  logic            unusedOperand;

  // The operand field belongs to the datapath; the sequencer ignores it.
  assign unusedOperand = ^iUop[4:0];

  // Flow-field decode and datapath strobes. The strobes are combinational
  // and only fire in EXEC when memory is ready. They are also held low
  // while reset is asserted, so a reset that lands mid-flow cannot leak a
  // half-executed micro-op into the datapath.
  always_comb begin
    flowCode = iUop[12:10];
    opField  = iUop[9:5];
    incBit   = 1'b0;
    fuBit    = 1'b0;
    eofHit   = 1'b0;
    condEof  = 1'b0;
    case (flowCode)
      3'd1: incBit = 1'b1;
      3'd2: eofHit = 1'b1;
      3'd3: begin incBit = 1'b1; eofHit = 1'b1; end
      3'd4: begin eofHit = 1'b1; fuBit = 1'b1; end
      3'd5: begin incBit = 1'b1; eofHit = 1'b1; fuBit = 1'b1; end
      3'd6: begin incBit = 1'b1; eofHit = iFlagZ;  condEof = iFlagZ;  end
      3'd7: begin incBit = 1'b1; eofHit = !iFlagZ; condEof = !iFlagZ; end
      default: ;
    endcase
    // A jump-to-CB micro-op is consumed by the sequencer, not the datapath.
    isJcb     = (opField == P_JCB_OP) && !eofHit;
    active    = (state_q == ST_EXEC) && iMemReady && !iReset;
    oPcInc    = active && incBit;
    oUopValid = active && !condEof && !isJcb;
    oFlagWe   = fuBit && oUopValid;
    oEof      = active && eofHit;
    oUaddr    = (state_q == ST_EXEC) ? upc_q : 8'd0;
  end

  // Next-state logic. In EXEC, end-of-flow outranks the CB jump, and the
  // CB jump outranks the watchdog. A stall (iMemReady low) holds every
  // register.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    upc_d    = upc_q;
    cb_d     = cb_q;
    wdog_d   = wdog_q;
    err_d    = err_q;
    icount_d = icount_q;
    wdogNext = wdog_q + 1'b1;
    case (state_q)
      ST_FETCH: begin
        if (iMemReady) begin
          ir_d    = iMdata;
          cb_d    = 1'b0;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        upc_d   = cb_q ? iCbFlowIdx : iFlowIdx;
        wdog_d  = '0;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (iMemReady) begin
          wdog_d = wdogNext;
          if (eofHit) begin
            icount_d = icount_q + 16'd1;
            state_d  = ST_FETCH;
          end else if (isJcb) begin
            ir_d    = iMdata;
            cb_d    = 1'b1;
            state_d = ST_DECODE;
          end else if (wdogNext == WDW'(P_WDOG_LIMIT)) begin
            err_d   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            upc_d = upc_q + 8'd1;
          end
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // State registers with synchronous reset. The watchdog error is sticky
  // and is cleared only by reset.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q  <= ST_FETCH;
      ir_q     <= 8'd0;
      upc_q    <= 8'd0;
      cb_q     <= 1'b0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
      icount_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      upc_q    <= upc_d;
      cb_q     <= cb_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
      icount_q <= icount_d;
    end
  end

  assign oIr        = ir_q;
  assign oUcodeErr  = err_q;
  assign oInstCount = icount_q;

endmodule

// File: tb/tb_dzcpu_useq.sv
// tb_dzcpu_useq - directed bench for the microcode sequencer.
//
// A behavioural ROM and two LUTs are modelled as arrays indexed by the
// sequencer's own address/IR outputs. Expected values are hand-computed
// per step. Inputs change 2 time units after the rising edge, and outputs
// are sampled 1 unit later.
module tb_dzcpu_useq;

  localparam logic [2:0] F_OP      = 3'd0;
  localparam logic [2:0] F_INC     = 3'd1;
  localparam logic [2:0] F_INC_EOF = 3'd3;
  localparam logic [2:0] F_EOF_FU  = 3'd4;
  localparam logic [2:0] F_EOF_Z  = 3'd6;
  localparam logic [2:0] F_EOF     = 3'd2;
  localparam logic [4:0] JCB       = 5'd31;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [7:0]  iMdata;
  logic        iMemReady;
  logic        iFlagZ;
  logic [12:0] iUop;
  logic [7:0]  iFlowIdx;
  logic [7:0]  iCbFlowIdx;
  logic [7:0]  oIr;
  logic [7:0]  oUaddr;
  logic        oUopValid;
  logic        oPcInc;
  logic        oFlagWe;
  logic        oEof;
  logic        oUcodeErr;
  logic [15:0] oInstCount;

  logic [12:0] rom     [256];
  logic [7:0]  mainLut [256];
  logic [7:0]  cbLut   [256];

  int errors = 0;
  int checks = 0;
  int cycles = 0;
  int startCycle;

  dzcpu_useq #(.P_JCB_OP(JCB), .P_WDOG_LIMIT(32)) dut (
    .iClock(iClock), .iReset(iReset), .iMdata(iMdata), .iMemReady(iMemReady),
    .iFlagZ(iFlagZ), .iUop(iUop), .iFlowIdx(iFlowIdx), .iCbFlowIdx(iCbFlowIdx),
    .oIr(oIr), .oUaddr(oUaddr), .oUopValid(oUopValid), .oPcInc(oPcInc),
    .oFlagWe(oFlagWe), .oEof(oEof), .oUcodeErr(oUcodeErr), .oInstCount(oInstCount)
  );

  always #5 iClock = ~iClock;

  // ROM and LUT models are combinational on the sequencer outputs.
  assign iUop       = rom[oUaddr];
  assign iFlowIdx   = mainLut[oIr];
  assign iCbFlowIdx = cbLut[oIr];

  function automatic logic [12:0] mk(input logic [2:0] f, input logic [4:0] op);
    return {f, op, 5'd0};
  endfunction

  // Advance one clock and step to the input-drive point.
  task automatic tick();
    @(posedge iClock);
    #2;
    cycles++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobes packed as {valid, pcInc, flagWe, eof}.
  task automatic checkStrobes(input string tag, input logic [3:0] exp);
    checkOutput(tag, {28'd0, oUopValid, oPcInc, oFlagWe, oEof}, {28'd0, exp});
  endtask

  task automatic applyStimulus(input logic [7:0] mdata, input logic ready, input logic z);
    iMdata    = mdata;
    iMemReady = ready;
    iFlagZ    = z;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]     = mk(F_OP, 5'd1);
      mainLut[i] = 8'd0;
      cbLut[i]   = 8'd0;
    end
    mainLut[8'h31] = 8'd1;
    rom[1] = mk(F_INC, 5'd1);
    rom[2] = mk(F_INC, 5'd1);
    rom[3] = mk(F_OP, 5'd1);
    rom[4] = mk(F_INC_EOF, 5'd1);
    mainLut[8'h40] = 8'd13;
    rom[13] = mk(F_INC, 5'd1);
    rom[14] = mk(F_OP, 5'd1);
    rom[15] = mk(F_INC, JCB);
    cbLut[8'h7C] = 8'd16;
    rom[16] = mk(F_EOF_FU, 5'd1);
    mainLut[8'h20] = 8'd17;
    rom[19] = mk(F_EOF_Z, 5'd1);
    rom[22] = mk(F_EOF, 5'd1);
    mainLut[8'h55] = 8'd100;

    iReset = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    tick();
    tick();
    iReset = 1'b0;
    #1;
    checkOutput("rstIr", oIr, 0);
    checkOutput("rstUaddr", oUaddr, 0);
    checkStrobes("rstStrobes", 4'b0000);
    checkOutput("rstErr", oUcodeErr, 0);
    checkOutput("rstCount", oInstCount, 0);

    // Basic 4-uop flow.
    applyStimulus(8'h31, 1'b1, 1'b0);
    checkStrobes("t1Fetch", 4'b0000);
    tick(); #1;
    checkOutput("t1Ir", oIr, 8'h31);
    checkStrobes("t1Decode", 4'b0000);
    tick(); #1; checkOutput("t1A1", oUaddr, 1); checkStrobes("t1S1", 4'b1100);
    tick(); #1; checkOutput("t1A2", oUaddr, 2); checkStrobes("t1S2", 4'b1100);
    tick(); #1; checkOutput("t1A3", oUaddr, 3); checkStrobes("t1S3", 4'b1000);
    tick(); #1; checkOutput("t1A4", oUaddr, 4); checkStrobes("t1S4", 4'b1101);
    tick(); #1;
    checkOutput("t1Count", oInstCount, 1);
    checkOutput("t1Fetch0", oUaddr, 0);
    checkStrobes("t1After", 4'b0000);

    // CB-prefixed flow through the jump-to-CB micro-op.
    applyStimulus(8'h40, 1'b1, 1'b0);
    tick();
    tick(); #1; checkOutput("t2A13", oUaddr, 13); checkStrobes("t2S13", 4'b1100);
    tick(); #1; checkOutput("t2A14", oUaddr, 14); checkStrobes("t2S14", 4'b1000);
    tick();
    applyStimulus(8'h7C, 1'b1, 1'b0);
    checkOutput("t2A15", oUaddr, 15);
    checkStrobes("t2Jcb", 4'b0100);
    tick(); #1;
    checkOutput("t2Ir", oIr, 8'h7C);
    checkStrobes("t2Decode", 4'b0000);
    tick(); #1;
    checkOutput("t2A16", oUaddr, 16);
    checkStrobes("t2S16", 4'b1011);
    tick(); #1;
    checkOutput("t2Count", oInstCount, 2);

    // Conditional end-of-flow, taken (Z=1).
    applyStimulus(8'h20, 1'b1, 1'b1);
    tick();
    tick(); #1; checkOutput("t3A17", oUaddr, 17);
    tick();
    tick(); #1; checkOutput("t3A19", oUaddr, 19); checkStrobes("t3Taken", 4'b0101);
    tick(); #1;
    checkOutput("t3CountA", oInstCount, 3);
    checkOutput("t3FetchA", oUaddr, 0);

    // Conditional end-of-flow, not taken (Z=0): runs on to uop 22.
    applyStimulus(8'h20, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    tick(); #1; checkStrobes("t3NotTaken", 4'b1100);
    tick();
    tick();
    tick(); #1; checkOutput("t3A22", oUaddr, 22); checkStrobes("t3S22", 4'b1001);
    tick(); #1;
    checkOutput("t3CountB", oInstCount, 4);

    // Three-cycle memory stall mid-flow.
    applyStimulus(8'h31, 1'b1, 1'b0);
    startCycle = cycles;
    tick();
    tick();
    tick();
    applyStimulus(8'h31, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t4HoldAddr", oUaddr, 2);
      checkStrobes("t4HoldStrobes", 4'b0000);
      if (k < 2) begin
        tick(); #1;
      end
    end
    tick();
    applyStimulus(8'h31, 1'b1, 1'b0);
    checkOutput("t4ResumeAddr", oUaddr, 2);
    checkStrobes("t4Resume", 4'b1100);
    tick();
    tick(); #1; checkStrobes("t4Eof", 4'b1101);
    tick(); #1;
    checkOutput("t4Cycles", cycles - startCycle, 9);
    checkOutput("t4Count", oInstCount, 5);

    // Runaway flow trips the watchdog after 32 micro-ops.
    applyStimulus(8'h55, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 32; k++) begin
      tick(); #1;
      checkOutput("t5Addr", oUaddr, 100 + k);
      checkStrobes("t5Strobes", 4'b1000);
    end
    checkOutput("t5ErrBefore", oUcodeErr, 0);
    tick(); #1;
    checkOutput("t5Err", oUcodeErr, 1);
    checkOutput("t5Count", oInstCount, 5);
    checkOutput("t5Fetch", oUaddr, 0);
    checkStrobes("t5After", 4'b0000);
    applyStimulus(8'h31, 1'b1, 1'b0);
    repeat (6) tick();
    #1;
    checkOutput("t5Sticky", oUcodeErr, 1);
    checkOutput("t5Count2", oInstCount, 6);

    // Reset asserted at uop 3 of a 4-uop flow.
    applyStimulus(8'h31, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    tick();
    iReset = 1'b1;
    #1;
    checkOutput("t6Addr3", oUaddr, 3);
    checkStrobes("t6RstCycle", 4'b0000);
    tick();
    iReset = 1'b0;
    #1;
    checkOutput("t6Uaddr", oUaddr, 0);
    checkStrobes("t6After", 4'b0000);
    checkOutput("t6Count", oInstCount, 0);
    checkOutput("t6Err", oUcodeErr, 0);
    checkOutput("t6Ir", oIr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dzcpu_useq.md
# dzcpu_useq

Microcode sequencer for the dzcpu core. It sits between the memory read path and the microcode ROM and LUTs. It latches macro opcodes (and the second byte of 0xCB-prefixed opcodes) into the instruction register and drives the instruction register into both flow LUTs. It then steps a micro-PC through the ROM, decodes each micro-op's flow-control field into strobes for the datapath, and terminates flows on end-of-flow codes.

## Interface
Parameters:
- P_JCB_OP, 5'd0 (set per op-field encoding): op-field value meaning "jump to CB flow".
- P_WDOG_LIMIT, 32: maximum micro-ops per macro instruction before forced abort.

Ports:
- iClock  in  1  core clock; one clock domain, all state updates on posedge.
- iReset  in  1  synchronous, active-high reset.
- iMdata  in  8  memory read data.
- iMemReady  in  1  memory cycle complete; low = stall.
- iFlagZ  in  1  current Z flag.
- iUop  in  13  ROM word at oUaddr, combinational, same cycle. Field split: [12:10] flow, [9:5] op, [4:0] operand.
- iFlowIdx  in  8  main LUT result for oIr.
- iCbFlowIdx  in  8  CB LUT result for oIr.
- oIr  out  8  instruction register; drives both LUTs.
- oUaddr  out  8  micro-ROM address.
- oUopValid  out  1  datapath executes iUop[9:0] this cycle.
- oPcInc  out  1  increment macro PC this cycle.
- oFlagWe  out  1  flag-update strobe.
- oEof  out  1  one-cycle pulse on instruction retire.
- oUcodeErr  out  1  sticky watchdog error.
- oInstCount  out  16  retired-instruction counter.

## Operation
Flow codes in iUop[12:10]:

| Code | Name | inc | eof | fu |
|---|---|---|---|---|
| 0 | op | – | – | – |
| 1 | inc | yes | – | – |
| 2 | eof | – | yes | – |
| 3 | inc_eof | yes | yes | – |
| 4 | eof_fu | – | yes | yes |
| 5 | inc_eof_fu | yes | yes | yes |
| 6 | inc_eof_z | yes | if iFlagZ=1 | – |
| 7 | inc_eof_nz | yes | if iFlagZ=0 | – |

States:
- FETCH:
  - oUaddr=0, strobes 0.
  - If iMemReady: oIr<=iMdata, rCb<=0, go DECODE.
- DECODE (one cycle, strobes 0):
  - uPC <= rCb ? iCbFlowIdx : iFlowIdx.
  - Watchdog count <= 0.
  - Go EXEC.
- EXEC:
  - oUaddr=uPC.
  - If !iMemReady: hold all state, strobes 0.
  - Otherwise:
    - oPcInc = inc bit.
    - oUopValid = 1, except when a conditional eof (codes 6/7) fires; then oUopValid=0.
    - oFlagWe = fu bit AND oUopValid.
    - Watchdog count increments.
  - Next-state priority, highest first, when not stalled:
    1. eof → FETCH, oEof=1, oInstCount++ (wraps at 16'hFFFF→0).
    2. op field == P_JCB_OP (and not eof) → oIr<=iMdata, rCb<=1, go DECODE. oUopValid=0 for this uop (it is sequencer-internal); inc is still honoured.
    3. Count reaches P_WDOG_LIMIT → oUcodeErr<=1, go FETCH, no oEof, counter unchanged.
    4. Else uPC<=uPC+1 (8-bit, 255 wraps to 0; wrap is not an error).
- Flow index 0 is a legal flow (generic 1-byte op). It is not treated as "unmapped".
- oUcodeErr clears only on iReset.

## Timing
- Reset values:
  - State FETCH.
  - oIr=0, oUaddr=0, uPC=0, rCb=0.
  - oUopValid, oPcInc, oFlagWe, oEof all 0.
  - oUcodeErr=0, oInstCount=0, watchdog count=0.
- iReset asserted mid-flow: all of the above takes effect at the next edge. No strobe is asserted in the reset cycle or the cycle after.
- Latency from opcode byte valid (iMemReady=1 in FETCH) to first uop strobe is 2 cycles: FETCH edge, then DECODE edge; EXEC strobes are in cycle 3.
- A flow of N uops with no stalls occupies N EXEC cycles. Instruction issue-to-issue is N+2 cycles.
- CB path adds 1 DECODE cycle after the jcb uop.
- Strobes are combinational from state, iUop, iFlagZ and iMemReady. They are asserted only in EXEC and only when iMemReady=1.
- Stall with a conditional eof: the condition is evaluated in the cycle iMemReady is high, using the iFlagZ value of that cycle.

## Test plan
1. Reset, then iMdata=8'h31 with LUT idx 1 and ROM flow {inc, inc, op, inc_eof} → oUaddr sequence 0,1,2,3,4; oPcInc high on uops 1, 2, 4; oEof once; oInstCount=1.
2. CB flow: main idx 13, ROM 13 {inc}, 14 {op}, 15 {inc, op=P_JCB_OP}; iMdata=8'h7C at uop 15; CB idx 16 = {eof_fu} → oIr=8'h7C after uop 15; oUaddr=16 two cycles later; oFlagWe=1 with oEof.
3. JRNZ at idx 17 with uop 19 = inc_eof_z: iFlagZ=1 → retire at uop 19 with oUopValid=0 and oPcInc=1. iFlagZ=0 → continues to uop 22, oEof at 22.
4. Drop iMemReady for 3 cycles mid-flow → oUaddr held, all strobes 0, flow resumes unchanged; total cycles = N+2+3.
5. Flow with no eof (ROM all op) → after 32 uops, oUcodeErr=1, return to FETCH, oInstCount unchanged. oUcodeErr stays set until iReset.
6. Assert iReset during EXEC at uop 3 of a 4-uop flow → next cycle state FETCH, oUaddr=0, no oEof, oInstCount=0.
